// File: rtl/add_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : add_err_monitor
// Description : Streaming error-characterisation block for a W-bit approximate
//               adder. Recomputes the exact sum of each accepted (a, b) pair,
//               compares it with the adder-under-test result o_dut and
//               accumulates saturating error statistics over a programmed
//               number of samples: sum of |err|, sum of err^2, worst |err| and
//               the count of erroneous samples.
// Options     : `define ADD_ERR_MONITOR_MSE_EN to build the squarer and the
//               sum_sq accumulator; otherwise sum_sq reads 0 and sat tracks
//               sum_abs only.
// Revision    : 1.0 - initial release
// ============================================================================
module add_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W:0]       o_dut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_abs,
  output logic [ACC_W-1:0] sum_sq,
  output logic [W:0]       max_abs,
  output logic             sat
);

  // Squared error width, and an adder width wide enough that neither the
  // accumulator nor any single increment can wrap before the overflow test.
  localparam int c_sq_w  = 2 * W + 2;
  localparam int c_sum_w = ((ACC_W > c_sq_w) ? ACC_W : c_sq_w) + 1;
  localparam logic [ACC_W-1:0] c_acc_max = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_accepted;

  // Stage 1: per-sample error registered on the acceptance edge
  logic             r_s1_valid;
  logic [W:0]       r_s1_abs;
  logic             r_s1_nz;

  // Stage 2: statistics
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [ACC_W-1:0] r_sum_abs;
  logic [W:0]       r_max_abs;
  logic             r_sat;

  logic             w_start;
  logic             w_xfer;
  logic [W:0]       w_exact;
  logic [W:0]       w_abs;
  logic             w_nz;
  logic             w_last_commit;
  logic [c_sum_w-1:0] w_abs_sum;
  logic             w_abs_ovf;
  logic             w_sq_ovf;

  // A start carrying a zero sample count is treated as if it never happened.
  assign w_start = start && (num_samples != '0);

  // Ready only while the run still needs samples, and never in a start cycle
  // so a restart cannot accept a sample that would immediately be flushed.
  assign in_ready = (r_state == ST_RUN) && (r_accepted < r_target) && !w_start;
  assign w_xfer   = in_valid && in_ready;

  // |exact - o_dut| computed as an unsigned magnitude, no sign handling needed.
  assign w_exact = {1'b0, a} + {1'b0, b};
  assign w_abs   = (w_exact >= o_dut) ? (w_exact - o_dut) : (o_dut - w_exact);
  assign w_nz    = (w_exact != o_dut);

  assign w_last_commit = r_s1_valid && ((r_sample_cnt + CNT_W'(1)) == r_target);

  assign w_abs_sum = c_sum_w'(r_sum_abs) + c_sum_w'(r_s1_abs);
  assign w_abs_ovf = (w_abs_sum > c_sum_w'(c_acc_max));

`ifdef ADD_ERR_MONITOR_MSE_EN
  logic [ACC_W-1:0]   r_sum_sq;
  logic [c_sq_w-1:0]  w_sq;
  logic [c_sum_w-1:0] w_sq_sum;

  assign w_sq     = c_sq_w'(r_s1_abs) * c_sq_w'(r_s1_abs);
  assign w_sq_sum = c_sum_w'(r_sum_sq) + c_sum_w'(w_sq);
  assign w_sq_ovf = (w_sq_sum > c_sum_w'(c_acc_max));

  // Saturating sum of squared errors, cleared whenever a run (re)starts
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_sum_sq <= '0;
    end else if (r_s1_valid) begin
      r_sum_sq <= w_sq_ovf ? c_acc_max : w_sq_sum[ACC_W-1:0];
    end
  end

  assign sum_sq = r_sum_sq;
`else
  assign w_sq_ovf = 1'b0;
  assign sum_sq   = '0;
`endif

  // Run-control FSM: tracks the target, accepted count and busy/done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_target   <= '0;
      r_accepted <= '0;
    end else if (w_start) begin
      r_state    <= ST_RUN;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_target   <= num_samples;
      r_accepted <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_xfer) begin
            r_accepted <= r_accepted + CNT_W'(1);
          end
          if (w_last_commit) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Stage 1: capture the error of an accepted sample; a restart flushes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_abs   <= '0;
      r_s1_nz    <= 1'b0;
    end else begin
      r_s1_valid <= w_xfer && !w_start;
      if (w_xfer) begin
        r_s1_abs <= w_abs;
        r_s1_nz  <= w_nz;
      end
    end
  end

  // Stage 2: fold the stage-1 sample into the running statistics
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_sum_abs    <= '0;
      r_max_abs    <= '0;
      r_sat        <= 1'b0;
    end else if (r_s1_valid) begin
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      if (r_s1_nz) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      r_sum_abs <= w_abs_ovf ? c_acc_max : w_abs_sum[ACC_W-1:0];
      if (r_s1_abs > r_max_abs) begin
        r_max_abs <= r_s1_abs;
      end
      r_sat <= r_sat || w_abs_ovf || w_sq_ovf;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign sum_abs    = r_sum_abs;
  assign max_abs    = r_max_abs;
  assign sat        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_add_err_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_add_err_monitor
// Description : Self-checking bench for add_err_monitor. A default instance
//               (ACC_W=32) and a narrow instance (ACC_W=10) share the same
//               stimulus; expected statistics come from a plain-arithmetic
//               model over the list of samples that should transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_err_monitor;

  localparam int W = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 32;
  localparam int SACC_W = 10;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [CNT_W-1:0] num_samples;
  logic [W-1:0] a, b;
  logic [W:0] o_dut;

  logic in_ready, busy, done, sat;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [ACC_W-1:0] sum_abs, sum_sq;
  logic [W:0] max_abs;

  logic s_in_ready, s_busy, s_done, s_sat;
  logic [CNT_W-1:0] s_sample_cnt, s_err_cnt;
  logic [SACC_W-1:0] s_sum_abs, s_sum_sq;
  logic [W:0] s_max_abs;

  add_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .o_dut(o_dut),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_abs(sum_abs), .sum_sq(sum_sq), .max_abs(max_abs), .sat(sat)
  );

  add_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(SACC_W)) u_small (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .o_dut(o_dut),
    .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
    .sum_abs(s_sum_abs), .sum_sq(s_sum_sq), .max_abs(s_max_abs), .sat(s_sat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Sample list offered to the DUT, in order
  int sa[64], sb[64], so[64];
  int ns;
  int lat, xfers;
  bit timed_out;

  // Expected values
  longint e_abs, e_sq, e_abs_s, e_sq_s;
  int e_max, e_err, e_cnt;
  bit e_sat, e_sat_s;

  // Reference: statistics of the first n samples, saturated at the cap.
  task automatic model(input int n);
    longint tabs, tsq, cap, scap;
    int d, ad;
    tabs = 0; tsq = 0; e_max = 0; e_err = 0;
    cap  = (64'd1 << ACC_W) - 1;
    scap = (64'd1 << SACC_W) - 1;
    for (int i = 0; i < n; i++) begin
      d  = sa[i] + sb[i] - so[i];
      ad = (d < 0) ? -d : d;
      tabs += ad;
      tsq  += longint'(ad) * ad;
      if (ad > e_max) e_max = ad;
      if (d != 0) e_err++;
    end
`ifndef ADD_ERR_MONITOR_MSE_EN
    tsq = 0;
`endif
    e_cnt   = n;
    e_abs   = (tabs > cap)  ? cap  : tabs;
    e_sq    = (tsq  > cap)  ? cap  : tsq;
    e_abs_s = (tabs > scap) ? scap : tabs;
    e_sq_s  = (tsq  > scap) ? scap : tsq;
    e_sat   = (tabs > cap)  || (tsq > cap);
    e_sat_s = (tabs > scap) || (tsq > scap);
  endtask

  // Pulse start, then offer samples (each cycle valid with pct% probability)
  // until done is seen; lat counts rising edges after the start edge.
  task automatic drive_run(input int n, input int pct);
    int idx;
    bit xf;
    idx = 0; xfers = 0; lat = 0; timed_out = 0;
    @(posedge clk); #1;
    start = 1'b1; num_samples = CNT_W'(n); in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    forever begin
      if (idx < ns && $urandom_range(99) < pct) begin
        in_valid = 1'b1;
        a = W'(sa[idx]); b = W'(sb[idx]); o_dut = (W+1)'(so[idx]);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (done) break;
      if (lat > 400) begin timed_out = 1; break; end
      xf = in_valid && in_ready;
      @(posedge clk); #1;
      lat++;
      if (xf) begin idx++; xfers++; end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    a = '0; b = '0; o_dut = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++; if ({busy, done, in_ready, sat, sample_cnt, err_cnt, sum_abs, sum_sq, max_abs} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b done=%b rdy=%b sat=%b cnt=%0d err=%0d abs=%0d sq=%0d max=%0d, required all 0",
                         busy, done, in_ready, sat, sample_cnt, err_cnt, sum_abs, sum_sq, max_abs);
    end
    // Zero-sample start from IDLE is ignored
    @(posedge clk); #1 start = 1'b1; num_samples = '0; in_valid = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_tests++; if ({busy, done, in_ready} !== 3'b000) begin
      n_fail++; $display("FAIL idle_zero_start: busy=%b done=%b rdy=%b, required 000", busy, done, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_exact;
    sa[0] = 3;   sb[0] = 5;   so[0] = 8;
    sa[1] = 255; sb[1] = 255; so[1] = 510;
    sa[2] = 0;   sb[2] = 0;   so[2] = 0;
    sa[3] = 100; sb[3] = 27;  so[3] = 127;
    ns = 4;
    drive_run(4, 100);
    model(4);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL exact_timeout: done=%b required 1", done); end
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL exact_latency: %0d edges, required 5", lat); end
    n_tests++; if (sample_cnt !== CNT_W'(e_cnt) || err_cnt !== CNT_W'(e_err)) begin
      n_fail++; $display("FAIL exact_counts: cnt=%0d err=%0d, required %0d %0d", sample_cnt, err_cnt, e_cnt, e_err);
    end
    n_tests++; if (sum_abs !== ACC_W'(e_abs) || sum_sq !== ACC_W'(e_sq) || max_abs !== (W+1)'(e_max)) begin
      n_fail++; $display("FAIL exact_sums: abs=%0d sq=%0d max=%0d, required %0d %0d %0d", sum_abs, sum_sq, max_abs, e_abs, e_sq, e_max);
    end
    n_tests++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL exact_flags: busy=%b done=%b, required 0 1", busy, done); end
  endtask

  task automatic test_offset;
    for (int i = 0; i < 4; i++) begin
      sa[i] = $urandom_range(240); sb[i] = $urandom_range(240); so[i] = sa[i] + sb[i] + 16;
    end
    ns = 4;
    drive_run(4, 70);
    model(4);
    n_tests++; if (sum_abs !== 32'd64 || max_abs !== 9'd16 || err_cnt !== 16'd4) begin
      n_fail++; $display("FAIL offset_stats: abs=%0d max=%0d err=%0d, required 64 16 4", sum_abs, max_abs, err_cnt);
    end
    n_tests++; if (sum_sq !== ACC_W'(e_sq)) begin n_fail++; $display("FAIL offset_sq: sq=%0d, required %0d", sum_sq, e_sq); end
  endtask

  task automatic test_done_hold;
    // start with zero samples and stray in_valid in DONE change nothing
    @(posedge clk); #1 start = 1'b1; num_samples = '0; in_valid = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({busy, done, in_ready} !== 3'b010 || sample_cnt !== CNT_W'(e_cnt) || sum_abs !== ACC_W'(e_abs)) begin
      n_fail++; $display("FAIL done_hold: busy=%b done=%b rdy=%b cnt=%0d abs=%0d, required 0 1 0 %0d %0d",
                         busy, done, in_ready, sample_cnt, sum_abs, e_cnt, e_abs);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mixed_sign;
    sa[0] = 10; sb[0] = 20; so[0] = 35;
    sa[1] = 50; sb[1] = 50; so[1] = 97;
    sa[2] = 1;  sb[2] = 2;  so[2] = 3;
    ns = 3;
    drive_run(3, 100);
    model(3);
    n_tests++; if (sum_abs !== 32'd8 || max_abs !== 9'd5 || err_cnt !== 16'd2 || sample_cnt !== 16'd3) begin
      n_fail++; $display("FAIL mixed_stats: abs=%0d max=%0d err=%0d cnt=%0d, required 8 5 2 3", sum_abs, max_abs, err_cnt, sample_cnt);
    end
    n_tests++; if (sum_sq !== ACC_W'(e_sq)) begin n_fail++; $display("FAIL mixed_sq: sq=%0d, required %0d", sum_sq, e_sq); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      sa[i] = $urandom_range(255); sb[i] = $urandom_range(255); so[i] = $urandom_range(511);
    end
    ns = 6;
    drive_run(3, 100);
    model(3);
    n_tests++; if (xfers != 3) begin n_fail++; $display("FAIL bp_transfers: %0d, required 3", xfers); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL bp_latency: %0d edges, required 4", lat); end
    n_tests++; if (in_ready !== 1'b0 || sample_cnt !== 16'd3) begin
      n_fail++; $display("FAIL bp_final: rdy=%b cnt=%0d, required 0 3", in_ready, sample_cnt);
    end
    n_tests++; if (sum_abs !== ACC_W'(e_abs) || err_cnt !== CNT_W'(e_err) || max_abs !== (W+1)'(e_max)) begin
      n_fail++; $display("FAIL bp_stats: abs=%0d err=%0d max=%0d, required %0d %0d %0d", sum_abs, err_cnt, max_abs, e_abs, e_err, e_max);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 3; i++) begin sa[i] = 0; sb[i] = 0; so[i] = 511; end
    ns = 3;
    drive_run(3, 100);
    model(3);
    n_tests++; if (s_sum_abs !== 10'd1023 || s_sat !== 1'b1 || s_max_abs !== 9'd511) begin
      n_fail++; $display("FAIL sat_small: abs=%0d sat=%b max=%0d, required 1023 1 511", s_sum_abs, s_sat, s_max_abs);
    end
    n_tests++; if (s_sum_sq !== SACC_W'(e_sq_s)) begin n_fail++; $display("FAIL sat_small_sq: sq=%0d, required %0d", s_sum_sq, e_sq_s); end
    n_tests++; if (sum_abs !== 32'd1533 || sat !== 1'b0 || sum_sq !== ACC_W'(e_sq)) begin
      n_fail++; $display("FAIL sat_wide: abs=%0d sat=%b sq=%0d, required 1533 0 %0d", sum_abs, sat, sum_sq, e_sq);
    end
  endtask

  task automatic test_random;
    int n, s;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(20, 5);
      for (int i = 0; i < n; i++) begin
        sa[i] = $urandom_range(255); sb[i] = $urandom_range(255);
        s = sa[i] + sb[i] + $urandom_range(40) - 20;
        so[i] = (s < 0) ? 0 : ((s > 511) ? 511 : s);
      end
      ns = n;
      drive_run(n, 60);
      model(n);
      n_tests++; if (timed_out || sample_cnt !== CNT_W'(e_cnt) || err_cnt !== CNT_W'(e_err)) begin
        n_fail++; $display("FAIL rand%0d_counts: to=%b cnt=%0d err=%0d, required 0 %0d %0d", it, timed_out, sample_cnt, err_cnt, e_cnt, e_err);
      end
      n_tests++; if (sum_abs !== ACC_W'(e_abs) || sum_sq !== ACC_W'(e_sq) || max_abs !== (W+1)'(e_max) || sat !== e_sat) begin
        n_fail++; $display("FAIL rand%0d_wide: abs=%0d sq=%0d max=%0d sat=%b, required %0d %0d %0d %b",
                           it, sum_abs, sum_sq, max_abs, sat, e_abs, e_sq, e_max, e_sat);
      end
      n_tests++; if (s_sum_abs !== SACC_W'(e_abs_s) || s_sum_sq !== SACC_W'(e_sq_s) || s_sat !== e_sat_s) begin
        n_fail++; $display("FAIL rand%0d_small: abs=%0d sq=%0d sat=%b, required %0d %0d %b",
                           it, s_sum_abs, s_sum_sq, s_sat, e_abs_s, e_sq_s, e_sat_s);
      end
    end
  endtask

  task automatic test_restart;
    @(posedge clk); #1 start = 1'b1; num_samples = 16'd5; in_valid = 1'b0;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; a = 8'd0; b = 8'd0; o_dut = 9'd200;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL restart_ready: rdy=%b, required 1", in_ready); end
    @(posedge clk); #1 a = 8'd1; b = 8'd1; o_dut = 9'd300;
    // Second sample transfers on the next edge and is still in flight when
    // the restart is accepted one edge later.
    sa[0] = 10; sb[0] = 10; so[0] = 30;
    ns = 1;
    drive_run(1, 100);
    model(1);
    n_tests++; if (timed_out || sample_cnt !== 16'd1 || err_cnt !== 16'd1) begin
      n_fail++; $display("FAIL restart_counts: to=%b cnt=%0d err=%0d, required 0 1 1", timed_out, sample_cnt, err_cnt);
    end
    n_tests++; if (sum_abs !== 32'd10 || max_abs !== 9'd10 || sum_sq !== ACC_W'(e_sq)) begin
      n_fail++; $display("FAIL restart_stats: abs=%0d max=%0d sq=%0d, required 10 10 %0d", sum_abs, max_abs, sum_sq, e_sq);
    end
  endtask

  task automatic test_mid_reset;
    @(posedge clk); #1 start = 1'b1; num_samples = 16'd10;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; a = 8'd7; b = 8'd9; o_dut = 9'd60;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if ({busy, done, in_ready, sat, sample_cnt, err_cnt, sum_abs, sum_sq, max_abs} !== '0) begin
      n_fail++; $display("FAIL mid_reset: busy=%b done=%b rdy=%b sat=%b cnt=%0d err=%0d abs=%0d sq=%0d max=%0d, required all 0",
                         busy, done, in_ready, sat, sample_cnt, err_cnt, sum_abs, sum_sq, max_abs);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({busy, sample_cnt} !== '0) begin
      n_fail++; $display("FAIL mid_reset_idle: busy=%b cnt=%0d, required 0 0", busy, sample_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_offset();
    test_done_hold();
    test_mixed_sign();
    test_back_to_back();
    test_saturation();
    test_random();
    test_restart();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
